// File: rtl/conv1d_stream_param_if.sv
// Stream bundle for conv1d_stream_param: filter load, sample load, result out.
// master = upstream/downstream side, slave = the convolution engine.
interface conv1d_stream_param_if #(
    parameter int T = 16
);
    logic signed [T-1:0] w_data;
    logic                w_valid;
    logic                w_ready;
    logic signed [T-1:0] x_data;
    logic                x_valid;
    logic                x_ready;
    logic                relu_en;
    logic signed [T-1:0] y_data;
    logic                y_valid;
    logic                y_ready;

    modport master (
        output w_data, w_valid, x_data, x_valid, relu_en, y_ready,
        input  w_ready, x_ready, y_data, y_valid
    );

    modport slave (
        input  w_data, w_valid, x_data, x_valid, relu_en, y_ready,
        output w_ready, x_ready, y_data, y_valid
    );
endinterface

// File: rtl/conv1d_stream_param.sv
// 1-D valid-mode convolution with runtime filter, P MAC lanes, shift/sat/ReLU.
// Ports: clk, reset (sync, active-low), bus (slave: w_*, x_*, relu_en, y_*).
module conv1d_stream_param #(
    parameter int N    = 96,
    parameter int M    = 65,
    parameter int T    = 16,
    parameter int P    = 16,
    parameter int FRAC = 0
) (
    input logic                  clk,
    input logic                  reset,
    conv1d_stream_param_if.slave bus
);
    localparam int XW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = (M > 1) ? $clog2(M) : 1;
    localparam int LW = (P > 1) ? $clog2(P) : 1;
    localparam int AW = 2 * T + $clog2(M) + 1;

    localparam logic signed [AW-1:0] YMAX = {{(AW-T+1){1'b0}}, {(T-1){1'b1}}};
    localparam logic signed [AW-1:0] YMIN = {{(AW-T+1){1'b1}}, {(T-1){1'b0}}};

    generate
        if (M < 1 || M > N || ((N - M + 1) % P) != 0) begin : g_bad_cfg
            $error("conv1d_stream_param: need 1<=M<=N and (N-M+1)%%P==0");
        end
    endgenerate

    typedef enum logic [2:0] {WLOAD, XLOAD, COMPUTE, RESULT, OUT} state_t;

    state_t state, state_n;

    logic [KW-1:0] wcnt, kcnt;
    logic [XW-1:0] xcnt, gbase;
    logic [LW-1:0] lane;
    logic          relu_q;
    logic          yv;
    logic signed [T-1:0] yd;

    logic signed [T-1:0]   f_mem [M];
    logic signed [T-1:0]   x_mem [N];
    logic signed [AW-1:0]  acc   [P];
    logic signed [T-1:0]   res   [P];
    logic [XW-1:0]         xi    [P];
    logic signed [2*T-1:0] prod  [P];
    logic signed [AW-1:0]  mac   [P];
    logic signed [T-1:0]   post  [P];

    logic w_hs, x_hs, y_hs;
    logic last_w, last_x, last_k, last_lane, last_grp;

    assign w_hs      = bus.w_valid && (state == WLOAD);
    assign x_hs      = bus.x_valid && (state == XLOAD);
    assign y_hs      = yv && bus.y_ready;
    assign last_w    = (wcnt == KW'(M - 1));
    assign last_x    = (xcnt == XW'(N - 1));
    assign last_k    = (kcnt == KW'(M - 1));
    assign last_lane = (lane == LW'(P - 1));
    assign last_grp  = (gbase == XW'(N - M + 1 - P));

    assign bus.w_ready = (state == WLOAD);
    assign bus.x_ready = (state == XLOAD);
    assign bus.y_valid = yv;
    assign bus.y_data  = yd;

    // Shift (floor), clamp to T bits, then optional ReLU.
    function automatic logic signed [T-1:0] finish(
        input logic signed [AW-1:0] a,
        input logic                 r
    );
        logic signed [AW-1:0] s;
        logic signed [T-1:0]  y;
        s = a >>> FRAC;
        if (s > YMAX)      y = YMAX[T-1:0];
        else if (s < YMIN) y = YMIN[T-1:0];
        else               y = s[T-1:0];
        if (r && y[T-1]) y = '0;
        return y;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state <= WLOAD;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            WLOAD:   if (w_hs && last_w) state_n = XLOAD;
            XLOAD:   if (x_hs && last_x) state_n = COMPUTE;
            COMPUTE: if (last_k) state_n = RESULT;
            RESULT:  state_n = OUT;
            OUT: begin
                if (y_hs && last_lane) begin
                    if (!last_grp)        state_n = COMPUTE;
                    else if (bus.w_valid) state_n = WLOAD;
                    else                  state_n = XLOAD;
                end
            end
            default: state_n = WLOAD;
        endcase
    end

    // Lane l of group g at tap k reads x[g*P + l + k]; kcnt==0 restarts the sum.
    always_comb begin
        for (int l = 0; l < P; l++) begin
            xi[l]   = gbase + XW'(kcnt) + XW'(l);
            prod[l] = (2*T)'(x_mem[xi[l]]) * (2*T)'(f_mem[kcnt]);
            mac[l]  = ((kcnt == '0) ? '0 : acc[l]) + AW'(prod[l]);
            post[l] = finish(acc[l], relu_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wcnt   <= '0;
            xcnt   <= '0;
            kcnt   <= '0;
            lane   <= '0;
            gbase  <= '0;
            relu_q <= 1'b0;
            yv     <= 1'b0;
            yd     <= '0;
        end else begin
            if (w_hs) wcnt <= last_w ? '0 : wcnt + 1'b1;
            if (x_hs) xcnt <= last_x ? '0 : xcnt + 1'b1;
            if (state == COMPUTE) kcnt <= last_k ? '0 : kcnt + 1'b1;
            if (state != COMPUTE && state_n == COMPUTE) relu_q <= bus.relu_en;
            // Output register: first OUT cycle loads lane 0, each accept advances.
            if (state == OUT) begin
                if (!yv) begin
                    yv <= 1'b1;
                    yd <= res[lane];
                end else if (bus.y_ready) begin
                    if (last_lane) begin
                        yv    <= 1'b0;
                        lane  <= '0;
                        gbase <= last_grp ? '0 : gbase + XW'(P);
                    end else begin
                        lane <= lane + 1'b1;
                        yd   <= res[lane + 1'b1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) f_mem[wcnt] <= bus.w_data;
        if (x_hs) x_mem[xcnt] <= bus.x_data;
        for (int l = 0; l < P; l++) begin
            if (state == COMPUTE) acc[l] <= mac[l];
            if (state == RESULT)  res[l] <= post[l];
        end
    end
endmodule

// File: tb/tb_conv1d_stream_param.sv
// Randomised scoreboard bench for conv1d_stream_param (N=8,M=3,P=2,T=8).
// Two DUTs share stimulus: FRAC=0 and FRAC=2.
module tb_conv1d_stream_param;
    localparam int N  = 8;
    localparam int M  = 3;
    localparam int P  = 2;
    localparam int T  = 8;
    localparam int NY = N - M + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv1d_stream_param_if #(.T(T)) ia ();
    conv1d_stream_param_if #(.T(T)) ib ();

    assign ib.w_data  = ia.w_data;
    assign ib.w_valid = ia.w_valid;
    assign ib.x_data  = ia.x_data;
    assign ib.x_valid = ia.x_valid;
    assign ib.relu_en = ia.relu_en;
    assign ib.y_ready = ia.y_ready;

    conv1d_stream_param #(.N(N), .M(M), .T(T), .P(P), .FRAC(0)) dut_a (
        .clk(clk), .reset(reset), .bus(ia)
    );
    conv1d_stream_param #(.N(N), .M(M), .T(T), .P(P), .FRAC(2)) dut_b (
        .clk(clk), .reset(reset), .bus(ib)
    );

    int errors = 0;
    int checks = 0;
    int fm [M];
    int xm [N];
    int qa [$];
    int qb [$];
    bit hold = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: direct sum, floor shift, clamp, ReLU.
    function automatic int ref_y(input int i, input int frac, input bit relu);
        int acc;
        acc = 0;
        for (int k = 0; k < M; k++) acc += xm[i + k] * fm[k];
        acc = acc >>> frac;
        if (acc > 127)  acc = 127;
        if (acc < -128) acc = -128;
        if (relu && acc < 0) acc = 0;
        return acc;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic xfer_w(input int v, input bit nogap);
        if (!nogap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        ia.w_data  = v[T-1:0];
        ia.w_valid = 1'b1;
        @(negedge clk);
        while (!ia.w_ready) @(negedge clk);
        @(posedge clk); #1;
        ia.w_valid = 1'b0;
    endtask

    task automatic xfer_x(input int v, input bit last_s, input bit relu);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if (last_s) ia.relu_en = relu;
        ia.x_data  = v[T-1:0];
        ia.x_valid = 1'b1;
        @(negedge clk);
        while (!ia.x_ready) @(negedge clk);
        @(posedge clk); #1;
        ia.x_valid = 1'b0;
    endtask

    task automatic send_filter();
        for (int k = 0; k < M; k++) xfer_w(fm[k], k == 0);
    endtask

    task automatic send_vec(input bit relu, input bit expect_out);
        if (expect_out) begin
            for (int i = 0; i < NY; i++) begin
                qa.push_back(ref_y(i, 0, relu));
                qb.push_back(ref_y(i, 2, relu));
            end
        end
        for (int j = 0; j < N; j++) xfer_x(xm[j], j == N - 1, relu);
    endtask

    task automatic rand_x();
        for (int j = 0; j < N; j++) xm[j] = rnd8();
    endtask

    task automatic drain();
        while (qa.size() != 0) @(negedge clk);
    endtask

    initial begin
        ia.y_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            ia.y_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset && ia.y_valid && ia.y_ready) begin
                check("y_valid_b", int'(ib.y_valid), 1);
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_output: got %0d expected none", ia.y_data);
                end else begin
                    check("y_frac0", ia.y_data, qa.pop_front());
                    check("y_frac2", ib.y_data, qb.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int d;
        reset      = 1'b0;
        ia.w_valid = 1'b0;
        ia.w_data  = '0;
        ia.x_valid = 1'b0;
        ia.x_data  = '0;
        ia.relu_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_w_ready", int'(ia.w_ready), 1);
        check("rst_x_ready", int'(ia.x_ready), 0);
        check("rst_y_valid", int'(ia.y_valid), 0);
        check("rst_y_data", ia.y_data, 0);
        reset = 1'b1;

        fm = '{1, 1, 1};
        send_filter();
        for (int j = 0; j < N; j++) xm[j] = j + 1;
        send_vec(1'b0, 1'b1);
        n = 0;
        while (!ia.y_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("first_latency", n, M + 2);

        fm = '{127, 127, 127};
        send_filter();
        for (int j = 0; j < N; j++) xm[j] = 127;
        send_vec(1'b0, 1'b1);

        fm = '{-128, -128, -128};
        send_filter();
        send_vec(1'b0, 1'b1);
        send_vec(1'b1, 1'b1);

        fm = '{1, 0, 0};
        send_filter();
        rand_x();
        xm[0] = -5;
        send_vec(1'b0, 1'b1);

        fm = '{1, 1, 0};
        send_filter();
        xm = '{7, 0, 0, 0, 0, 0, 0, 0};
        send_vec(1'b0, 1'b1);

        drain();
        hold = 1'b1;
        rand_x();
        send_vec(1'b0, 1'b1);
        n = 0;
        while (!ia.y_valid && n < 50) begin @(negedge clk); n++; end
        check("bp_valid_seen", int'(ia.y_valid), 1);
        d = ia.y_data;
        repeat (10) begin
            @(negedge clk);
            check("bp_y_valid", int'(ia.y_valid), 1);
            check("bp_y_data", ia.y_data, d);
            check("bp_x_ready", int'(ia.x_ready), 0);
        end
        hold = 1'b0;

        rand_x();
        send_vec(1'b1, 1'b1);

        for (int k = 0; k < M; k++) fm[k] = rnd8();
        send_filter();
        rand_x();
        send_vec(1'b0, 1'b1);

        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < M; k++) fm[k] = rnd8();
                send_filter();
            end
            rand_x();
            send_vec(1'($urandom_range(0, 1)), 1'b1);
        end

        drain();
        rand_x();
        send_vec(1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_y_valid", int'(ia.y_valid), 0);
        check("mid_rst_w_ready", int'(ia.w_ready), 1);
        check("mid_rst_x_ready", int'(ia.x_ready), 0);
        reset = 1'b1;

        for (int k = 0; k < M; k++) fm[k] = rnd8();
        send_filter();
        rand_x();
        send_vec(1'b1, 1'b1);
        rand_x();
        send_vec(1'b0, 1'b1);

        drain();
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
